// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_pkg
// Purpose  : Shared types and field positions for RV32I immediate packing.
//            The immediate-source enum is also used by the decode-side
//            immediate extender, so its encoding must not change.
// Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

  // Immediate format code, same 2-bit encoding as the decode stage
  typedef enum logic [1:0] {
    IMM_I   = 2'd0,
    IMM_S   = 2'd1,
    IMM_B   = 2'd2,
    IMM_RSV = 2'd3
  } imm_src_t;

  // Elastic buffer depth
  localparam int unsigned IMM_FIFO_DEPTH = 2;

  // Field positions inside the instruction word
  localparam int unsigned c_i_imm_lsb  = 20;  // I: instr[31:20] = imm[11:0]
  localparam int unsigned c_s_hi_lsb   = 25;  // S: instr[31:25] = imm[11:5]
  localparam int unsigned c_s_lo_lsb   = 7;   // S: instr[11:7]  = imm[4:0]
  localparam int unsigned c_b_b12_bit  = 31;  // B: instr[31]    = imm[12]
  localparam int unsigned c_b_b11_bit  = 7;   // B: instr[7]     = imm[11]
  localparam int unsigned c_b_hi_lsb   = 25;  // B: instr[30:25] = imm[10:5]
  localparam int unsigned c_b_lo_lsb   = 8;   // B: instr[11:8]  = imm[4:1]

  // One buffered result
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } imm_entry_t;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder_if
// Purpose  : Request/response handshake bundle for the immediate encoder.
//            master drives requests and accepts results; slave is the encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_encoder_if;
  import imm_pkg::*;

  logic        in_valid;
  logic        in_ready;
  imm_src_t    in_src;
  logic [31:0] in_imm;
  logic [31:0] in_base;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_src, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_src, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface : imm_encoder_if
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
// Module   : imm_pack
// Purpose  : Combinational packer. Writes the immediate bits of the selected
//            format into the template and flags values that do not fit.
//            Out-of-range values are still written with truncated bits.
// Revision : 1.0 - initial release
// ============================================================================
module imm_pack
  import imm_pkg::*;
(
  input  imm_src_t    src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        err
);

  // A value fits 12 bits signed when bits 31..11 are a pure sign extension
  logic w_fits12;
  // A value fits 13 bits signed when bits 31..12 are a pure sign extension
  logic w_fits13;

  assign w_fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_fits13 = (&imm[31:12]) | ~(|imm[31:12]);

  // Overlay the immediate fields on the template and range-check per format
  always_comb begin
    instr = base;
    err   = 1'b0;
    case (src)
      IMM_I: begin
        instr[31:c_i_imm_lsb] = imm[11:0];
        err                   = ~w_fits12;
      end
      IMM_S: begin
        instr[31:c_s_hi_lsb]             = imm[11:5];
        instr[c_s_lo_lsb+4:c_s_lo_lsb]   = imm[4:0];
        err                              = ~w_fits12;
      end
      IMM_B: begin
        instr[c_b_b12_bit]               = imm[12];
        instr[c_b_b11_bit]               = imm[11];
        instr[c_b_hi_lsb+5:c_b_hi_lsb]   = imm[10:5];
        instr[c_b_lo_lsb+3:c_b_lo_lsb]   = imm[4:1];
        // branch offsets are halfword aligned
        err                              = ~w_fits13 | imm[0];
      end
      default: begin
        // reserved format: template passes untouched, always an error
        instr = base;
        err   = 1'b1;
      end
    endcase
  end

endmodule : imm_pack
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Streams immediate-packing requests through a 2-entry elastic
//            buffer with valid/ready on both sides and keeps a saturating
//            count of accepted requests that were flagged as errors.
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder
  import imm_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  imm_encoder_if.slave     bus,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] c_full = 2'(IMM_FIFO_DEPTH);

  imm_entry_t       r_mem [IMM_FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [ERR_W-1:0] r_err_count;

  logic [31:0]      w_instr;
  logic             w_err;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  imm_pack u_pack (
    .src   (bus.in_src),
    .imm   (bus.in_imm),
    .base  (bus.in_base),
    .instr (w_instr),
    .err   (w_err)
  );

  // Handshakes come from registered occupancy; both are held low in reset
  // so no transfer can complete in a reset cycle.
  assign bus.in_ready  = ~rst & (r_count != c_full);
  assign bus.out_valid = ~rst & (r_count != 2'd0);
  assign bus.out_instr = bus.out_valid ? r_mem[r_rd_ptr].instr : 32'd0;
  assign bus.out_err   = bus.out_valid ? r_mem[r_rd_ptr].err   : 1'b0;
  assign err_count     = r_err_count;

  assign w_push = bus.in_valid  & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  // Next occupancy; push and pop together leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Buffer storage, pointers and occupancy; reset discards buffered entries
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(IMM_FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{instr: w_instr, err: w_err};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
    end
  end

  // Saturating error counter; clear has priority over an increment
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_err_count <= '0;
    end else if (w_push && w_err && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule : imm_encoder
`default_nettype wire

// File: doc/imm_encoder.md
# imm_encoder

- Packs a 32-bit signed immediate into the immediate bit fields of an RV32I instruction template, selected by the same 2-bit immediate-source code the decode stage uses.
- Range-checks each value and flags any immediate that does not fit its format.
- Sits on the assembler/patch path that feeds instruction memory, the write side of the immediate path.
- Streams with valid/ready on both sides through a 2-entry elastic buffer, and keeps a saturating error count.

## Interface
Parameters:
- ERR_W, 16, width of the error counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_src  in  2  immediate format, imm_pkg::imm_src_t
- in_imm  in  32  signed immediate value
- in_base  in  32  instruction template; non-immediate bits pass through
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_instr  out  32  packed instruction
- out_err  out  1  range/format error for this result
- err_clr  in  1  clears err_count
- err_count  out  ERR_W  saturating count of accepted requests with error

## Operation
Packing writes only the immediate field bits. All other bits equal in_base.
- IMM_I (0): instr[31:20] = imm[11:0].
  - Error unless imm[31:11] are all equal.
- IMM_S (1): instr[31:25] = imm[11:5]; instr[11:7] = imm[4:0].
  - Same range rule as IMM_I.
- IMM_B (2): instr[31] = imm[12]; instr[7] = imm[11]; instr[30:25] = imm[10:5]; instr[11:8] = imm[4:1].
  - Error unless imm[31:12] are all equal and imm[0] == 0.
- IMM_RSV (3): out_instr = in_base unchanged; out_err = 1.
- On error the fields are still written with the truncated bits. The result is never dropped.
- Packing and range check are combinational on the input. The result is written into the buffer on acceptance.
- Buffer: 2 entries, strict FIFO order.
  - in_ready = (occupancy < 2), driven from registered state.
  - out_valid = (occupancy > 0).
- err_count: increments by 1 on each accepted request whose error is 1.
  - Saturates at all-ones.
  - err_clr forces 0 and wins over a simultaneous increment.

## Timing
- Reset values:
  - in_ready = 0 while rst is high, then 1 in the first cycle after.
  - out_valid = 0, out_instr = 0, out_err = 0, err_count = 0.
  - Occupancy = 0.
- Latency: a request accepted in cycle N is presented on out_* in cycle N+1 when the buffer was empty.
- Throughput: 1 per cycle while out_ready = 1.
- Simultaneous push and pop at occupancy 1 or 2: occupancy is unchanged and order is preserved.
  - A push with in_ready = 0 is ignored by the protocol.
- out_instr and out_err hold stable while out_valid && !out_ready.
- rst mid-stream: both buffered entries are discarded and err_count is cleared in the same cycle. No output handshake completes in the reset cycle.
- in_src, in_imm and in_base are sampled only on acceptance.

## Structure
- imm_pkg holds:
  - imm_src_t enum: IMM_I = 2'd0, IMM_S, IMM_B, IMM_RSV. Shared with the decode-side immediate extender.
  - Field position constants.
  - IMM_FIFO_DEPTH = 2.
- Sub-module imm_pack: purely combinational, takes (src, imm, base) and returns (instr, err). It is reused by the testbench model.
- imm_encoder contains the 2-entry buffer, the handshake logic and the counter.

## Test plan
- I-type: base 0x00000013, imm 0xFFFFFFFF, out_ready = 1 -> cycle +1: out_instr 0xFFF00013, out_err 0.
- S-type: base 0x00002023, imm 0x000007FF -> out_instr 0x7E002FA3, out_err 0.
- B-type: base 0x00000063, imm 0xFFFFFFFC -> out_instr 0xFE000EE3.
  - Then imm 0x00000003 -> out_err 1, err_count 1.
- Range error, I-type: imm 0x00000800 with base 0x00000013 -> out_instr 0x80000013, out_err 1, err_count increments.
  - in_src 3 with base 0x12345678 -> out_instr 0x12345678, out_err 1.
- Backpressure: out_ready = 0, drive three back-to-back requests -> two accepted, in_ready drops to 0, third held.
  - Raise out_ready -> all three emerge in order, one per cycle, output stable while stalled.
- Counter and reset:
  - Preload err_count to all-ones via errors -> stays all-ones on further errors.
  - err_clr with a simultaneous error -> 0.
  - rst with 2 entries buffered -> out_valid 0 the next cycle, no stale output afterward.
